// File: rtl/icache_fetcher_pkg.sv
// icache_fetcher_pkg: shared word types, logic constants and fetch fsm encodings
package icache_fetcher_pkg;
  localparam int ADDR_W = 32;
  localparam int INSTR_W = 32;
  typedef logic [ADDR_W-1:0] AddrType;
  typedef logic [INSTR_W-1:0] InstrType;
  localparam InstrType ZeroWord = '0;
  localparam logic True = 1'b1;
  localparam logic False = 1'b0;
  typedef enum logic [1:0] {IF_IDLE = 2'd0, IF_MISS = 2'd1, IF_DROP = 2'd2} if_state_e;
endpackage

// File: rtl/icache_dm.sv
// icache_dm: direct-mapped one-word-per-line cache with combinational read, fill port and invalidate-all
module icache_dm import icache_fetcher_pkg::*; #(
  parameter int ADDR_WIDTH = 32,
  parameter int INSTR_WIDTH = 32,
  parameter int INDEX_BITS = 6
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [ADDR_WIDTH-1:2]  rd_addr_i,
  output logic                   hit_o,
  output logic [INSTR_WIDTH-1:0] rd_data_o,
  input  logic                   wr_en_i,
  input  logic [ADDR_WIDTH-1:2]  wr_addr_i,
  input  logic [INSTR_WIDTH-1:0] wr_data_i,
  input  logic                   inval_i
);
  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = ADDR_WIDTH - INDEX_BITS - 2;
  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_q [LINES];
  logic [INSTR_WIDTH-1:0] data_q [LINES];
  logic [INDEX_BITS-1:0] rd_idx, wr_idx;
  assign rd_idx = rd_addr_i[INDEX_BITS+1:2];
  assign wr_idx = wr_addr_i[INDEX_BITS+1:2];
  assign hit_o = valid_q[rd_idx] && tag_q[rd_idx] == rd_addr_i[ADDR_WIDTH-1:INDEX_BITS+2];
  assign rd_data_o = data_q[rd_idx];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)
      valid_q <= '0;
    else if (inval_i)
      valid_q <= '0;
    else if (wr_en_i)
      valid_q[wr_idx] <= True;
  always_ff @(posedge clk)
    if (wr_en_i) begin
      tag_q[wr_idx] <= wr_addr_i[ADDR_WIDTH-1:INDEX_BITS+2];
      data_q[wr_idx] <= wr_data_i;
    end
endmodule

// File: rtl/icache_fetcher.sv
// icache_fetcher: owns the fetch pc and serves one instruction per queue request through a direct-mapped icache
module icache_fetcher import icache_fetcher_pkg::*; #(
  parameter int ADDR_WIDTH = 32,
  parameter int INSTR_WIDTH = 32,
  parameter int INDEX_BITS = 6,
  parameter int PC_STEP = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   rdy,
  input  logic                   clear_flag_in,
  input  logic [ADDR_WIDTH-1:0]  clear_pc_in,
  input  logic                   icache_inval_in,
  output logic                   mc_fetch_enable_out,
  output logic [ADDR_WIDTH-1:0]  mc_addr_out,
  input  logic                   mc_result_enable_in,
  input  logic [INSTR_WIDTH-1:0] mc_data_in,
  input  logic                   iq_fetch_enable_in,
  output logic [INSTR_WIDTH-1:0] iq_instr_out,
  output logic [ADDR_WIDTH-1:0]  iq_pc_out,
  output logic                   iq_result_enable_out
);
  if_state_e state_q;
  logic [ADDR_WIDTH-1:0] pc_q, pc_inc;
  logic hit, fill;
  logic [INSTR_WIDTH-1:0] hit_data;
  assign pc_inc = pc_q + ADDR_WIDTH'(PC_STEP);
  assign fill = rdy && mc_result_enable_in && state_q != IF_IDLE;
  icache_dm #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .INSTR_WIDTH(INSTR_WIDTH),
    .INDEX_BITS(INDEX_BITS)
  ) u_cache (
    .clk(clk),
    .rst_n(rst_n),
    .rd_addr_i(pc_q[ADDR_WIDTH-1:2]),
    .hit_o(hit),
    .rd_data_o(hit_data),
    .wr_en_i(fill),
    .wr_addr_i(mc_addr_out[ADDR_WIDTH-1:2]),
    .wr_data_i(mc_data_in),
    .inval_i(rdy && icache_inval_in)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IF_IDLE;
      pc_q <= '0;
      mc_fetch_enable_out <= False;
      mc_addr_out <= '0;
      iq_result_enable_out <= False;
      iq_instr_out <= '0;
      iq_pc_out <= '0;
    end else if (rdy) begin
      iq_result_enable_out <= False;
      if (clear_flag_in)
        pc_q <= clear_pc_in;
      case (state_q)
        IF_IDLE:
          if (!clear_flag_in && iq_fetch_enable_in) begin
            if (hit) begin
              iq_result_enable_out <= True;
              iq_instr_out <= hit_data;
              iq_pc_out <= pc_q;
              pc_q <= pc_inc;
            end else begin
              mc_fetch_enable_out <= True;
              mc_addr_out <= pc_q;
              state_q <= IF_MISS;
            end
          end
        IF_MISS:
          if (mc_result_enable_in) begin
            mc_fetch_enable_out <= False;
            state_q <= IF_IDLE;
            if (!clear_flag_in) begin
              iq_result_enable_out <= True;
              iq_instr_out <= mc_data_in;
              iq_pc_out <= mc_addr_out;
              pc_q <= pc_inc;
            end
          end else if (clear_flag_in)
            state_q <= IF_DROP;
        IF_DROP:
          if (mc_result_enable_in) begin
            mc_fetch_enable_out <= False;
            state_q <= IF_IDLE;
          end
        default: state_q <= IF_IDLE;
      endcase
    end
endmodule

// File: tb/tb_icache_fetcher.sv
// tb_icache_fetcher: directed and random fetch traffic checked against a transaction-level cache model
module tb_icache_fetcher;
  logic clk = 0;
  logic rst_n, rdy, clear_flag_in, icache_inval_in, mc_result_enable_in, iq_fetch_enable_in;
  logic [31:0] clear_pc_in, mc_data_in;
  logic mc_fetch_enable_out, iq_result_enable_out;
  logic [31:0] mc_addr_out, iq_instr_out, iq_pc_out;
  int nvec = 0, nerr = 0;
  logic [31:0] m_pc, m_req, e_mca, e_instr, e_ipc;
  bit m_busy, m_drop, e_mcf, e_pulse, rand_lat;
  bit [63:0] m_valid;
  logic [31:0] m_line [64];
  int mc_lat, mc_cnt;
  always #5 clk = ~clk;
  icache_fetcher dut (
    .clk(clk),
    .rst_n(rst_n),
    .rdy(rdy),
    .clear_flag_in(clear_flag_in),
    .clear_pc_in(clear_pc_in),
    .icache_inval_in(icache_inval_in),
    .mc_fetch_enable_out(mc_fetch_enable_out),
    .mc_addr_out(mc_addr_out),
    .mc_result_enable_in(mc_result_enable_in),
    .mc_data_in(mc_data_in),
    .iq_fetch_enable_in(iq_fetch_enable_in),
    .iq_instr_out(iq_instr_out),
    .iq_pc_out(iq_pc_out),
    .iq_result_enable_out(iq_result_enable_out)
  );
  function automatic logic [31:0] memw(input logic [31:0] a);
    return (a == 32'h0) ? 32'h13 : (a * 32'h9E3779B1) ^ 32'h5BD1E995;
  endfunction
  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    nvec++;
    assert (o === e) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask
  task automatic check_all(input string tag);
    chk({tag, ":mc_fetch"}, {31'd0, mc_fetch_enable_out}, {31'd0, e_mcf});
    chk({tag, ":mc_addr"}, mc_addr_out, e_mca);
    chk({tag, ":iq_valid"}, {31'd0, iq_result_enable_out}, {31'd0, e_pulse});
    chk({tag, ":iq_instr"}, iq_instr_out, e_instr);
    chk({tag, ":iq_pc"}, iq_pc_out, e_ipc);
  endtask
  task automatic model_reset();
    m_pc = 0; m_req = 0; m_busy = 0; m_drop = 0; m_valid = '0;
    e_mcf = 0; e_mca = 0; e_pulse = 0; e_instr = 0; e_ipc = 0; mc_cnt = 0;
  endtask
  task automatic cyc(input bit f, input bit c, input logic [31:0] cp, input bit inv, input bit r);
    bit res;
    int idx;
    res = r && mc_fetch_enable_out && mc_cnt >= mc_lat;
    iq_fetch_enable_in = f; clear_flag_in = c; clear_pc_in = cp; icache_inval_in = inv; rdy = r;
    mc_result_enable_in = res;
    mc_data_in = res ? memw(mc_addr_out) : $urandom;
    if (r) begin
      e_pulse = 0;
      if (!m_busy) begin
        if (c) m_pc = cp;
        else if (f) begin
          idx = int'(m_pc[7:2]);
          if (m_valid[idx] && m_line[idx][31:8] == m_pc[31:8]) begin
            e_pulse = 1; e_instr = memw(m_line[idx]); e_ipc = m_pc; m_pc = m_pc + 4;
          end else begin
            m_busy = 1; m_drop = 0; m_req = m_pc; e_mca = m_pc;
            if (rand_lat) mc_lat = $urandom_range(0, 4);
          end
        end
      end else begin
        if (res) begin
          idx = int'(m_req[7:2]);
          m_valid[idx] = 1; m_line[idx] = m_req;
          if (!m_drop && !c) begin
            e_pulse = 1; e_instr = memw(m_req); e_ipc = m_req; m_pc = m_req + 4;
          end
          m_busy = 0;
        end
        if (c) begin m_pc = cp; m_drop = 1; end
      end
      if (inv) m_valid = '0;
      e_mcf = m_busy;
    end
    @(posedge clk); #1;
    if (!mc_fetch_enable_out) mc_cnt = 0;
    else if (r && !res) mc_cnt++;
    check_all("cyc");
  endtask
  task automatic drain();
    for (int i = 0; i < 40 && m_busy; i++) cyc(0, 0, 0, 0, 1);
    chk("drain_timeout", {31'd0, mc_fetch_enable_out}, 32'd0);
  endtask
  initial begin
    logic [31:0] cp;
    rst_n = 0; rdy = 0; clear_flag_in = 0; clear_pc_in = 0; icache_inval_in = 0;
    mc_result_enable_in = 0; mc_data_in = 0; iq_fetch_enable_in = 0;
    rand_lat = 0; mc_lat = 3;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    check_all("reset");
    cyc(1, 0, 0, 0, 1);
    drain();
    cyc(0, 1, 0, 0, 1);
    cyc(1, 0, 0, 0, 1);
    chk("hit_pulse", {31'd0, iq_result_enable_out}, 32'd1);
    chk("hit_instr", iq_instr_out, 32'h13);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 1, 32'h8, 0, 1);
    cyc(1, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 1, 32'h100, 0, 1);
    drain();
    cyc(1, 0, 0, 0, 1);
    drain();
    cyc(0, 1, 32'h8, 0, 1);
    cyc(1, 0, 0, 0, 1);
    cyc(0, 1, 32'h0, 0, 1);
    cyc(1, 0, 0, 0, 1);
    chk("conflict_miss", {31'd0, mc_fetch_enable_out}, 32'd1);
    drain();
    cyc(0, 1, 32'h0, 0, 1);
    cyc(0, 0, 0, 1, 1);
    cyc(1, 0, 0, 0, 1);
    chk("inval_miss", {31'd0, mc_fetch_enable_out}, 32'd1);
    drain();
    mc_lat = 8;
    cyc(0, 1, 32'h4, 0, 1);
    cyc(1, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    repeat (5) cyc(1, 1, 32'h200, 1, 0);
    drain();
    cyc(0, 1, 32'h4, 0, 1);
    cyc(1, 0, 0, 0, 1);
    repeat (3) cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);
    mc_lat = 1;
    cyc(0, 1, 32'hFFFF_FFFC, 0, 1);
    cyc(1, 0, 0, 0, 1);
    drain();
    cyc(1, 0, 0, 0, 1);
    chk("wrap_hit_pc", iq_pc_out, 32'h0);
    mc_lat = 8;
    cyc(0, 1, 32'h40, 0, 1);
    cyc(1, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    #2 rst_n = 0;
    #1;
    model_reset();
    check_all("async_reset");
    @(posedge clk); #1;
    rst_n = 1;
    check_all("post_reset");
    rand_lat = 1;
    for (int i = 0; i < 700; i++) begin
      cp = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FF00 | 32'($urandom_range(0, 63) << 2)) : 32'($urandom_range(0, 127) << 2);
      if ($urandom_range(0, 7) == 0) cp = cp | 32'($urandom_range(0, 3));
      cyc($urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0, cp, $urandom_range(0, 29) == 0, $urandom_range(0, 99) < 85);
    end
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/icache_fetcher.md
Name: icache_fetcher

Overview:
Parametrised next-generation instruction fetch unit with an integrated direct-mapped instruction cache. It sits between the instruction queue and the memory controller. It owns the fetch PC and serves one instruction per queue request: hits return in 1 cycle, misses go through the memory controller. Branch redirects cleanly abort or drain an in-flight miss, so a stale instruction can never reach the queue.

Parameters:
ADDR_WIDTH, 32, width of PC and memory addresses
INSTR_WIDTH, 32, instruction/word width
INDEX_BITS, 6, log2 of cache line count (64 lines, one word per line)
PC_STEP, 4, PC increment per delivered instruction

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
rdy  in  1  global ready; low freezes all state and outputs
clear_flag_in  in  1  redirect (mispredict/flush) this cycle
clear_pc_in  in  ADDR_WIDTH  redirect target PC
icache_inval_in  in  1  invalidate all cache lines (fence.i)
mc_fetch_enable_out  out  1  memory read request, level, held until result
mc_addr_out  out  ADDR_WIDTH  memory read address
mc_result_enable_in  in  1  one-cycle pulse, mc_data_in valid
mc_data_in  in  INSTR_WIDTH  returned word
iq_fetch_enable_in  in  1  queue has room; request next instruction
iq_instr_out  out  INSTR_WIDTH  delivered instruction
iq_pc_out  out  ADDR_WIDTH  PC of delivered instruction
iq_result_enable_out  out  1  one-cycle pulse, instruction valid

Behaviour:
- Reset (async, rst_n=0): pc=0, state=IDLE, all valid bits=0, mc_fetch_enable_out=0, mc_addr_out=0, iq_result_enable_out=0, iq_instr_out=0, iq_pc_out=0. Tag/data arrays are not reset.
- Address split: index=pc[INDEX_BITS+1:2], tag=pc[ADDR_WIDTH-1:INDEX_BITS+2]. pc[1:0] is ignored.
- rdy=0: no state changes; outputs hold. The exception is iq_result_enable_out, which also holds; the queue is frozen by the same rdy.
- iq_result_enable_out defaults to 0 every active cycle. It is never high for 2 consecutive cycles.
- States:
  - IDLE:
    - iq_fetch_enable_in=1 and hit (valid[index] && tag match): next cycle iq_result_enable_out=1, iq_instr_out=data, iq_pc_out=pc; pc<=pc+PC_STEP. State stays IDLE.
    - iq_fetch_enable_in=1 and miss: mc_fetch_enable_out<=1, mc_addr_out<=pc; go MISS.
  - MISS: wait for mc_result_enable_in. On the result:
    - write data, tag and valid for index(mc_addr_out);
    - pulse iq_result_enable_out with iq_instr_out=mc_data_in and iq_pc_out=mc_addr_out;
    - pc<=pc+PC_STEP; mc_fetch_enable_out<=0; go IDLE.
  - DROP: the memory controller cannot abort, so the request stays asserted. On mc_result_enable_in: fill the cache line (the data is correct for mc_addr_out), deliver nothing, mc_fetch_enable_out<=0, go IDLE.
- Redirect: clear_flag_in has priority over everything. pc<=clear_pc_in and no delivery occurs this cycle.
  - From IDLE: stay IDLE.
  - From MISS without a same-cycle result: go DROP.
  - From MISS with a same-cycle result: fill the line, deliver nothing, go IDLE.
  - From DROP: stay DROP.
- A fetch request seen in MISS or DROP is ignored; the queue re-asserts it.
- Invalidate: icache_inval_in clears all valid bits next cycle. If it coincides with a fill, the invalidate wins and the line ends invalid. An in-flight miss still delivers its word.
- PC arithmetic is modulo 2^ADDR_WIDTH; wrap to 0 is legal.
- Hit lookup is combinational from registered arrays, giving 1-cycle latency from request to pulse. Miss latency is the memory controller latency plus 1.

Decomposition:
- Shared defines package holds: AddrType, InstrType, ZeroWord, True/False, and the FSM state encodings (IF_IDLE, IF_MISS, IF_DROP).
- One sub-module, icache_dm: valid/tag/data arrays with combinational read (hit, data), write port, and invalidate-all. The fetcher keeps the FSM, the PC and both handshakes.

Test Plan:
- Cold miss: reset, release, fetch at pc=0, mc returns 0x00000013 after 3 cycles -> mc_addr_out=0 held high until the result; then iq pulse instr=0x13, pc_out=0; pc becomes 4.
- Hit: redirect to 0, fetch again -> iq pulse exactly 1 cycle later with instr=0x13, no mc request.
- Redirect mid-miss: miss at 0x8, clear_flag_in with clear_pc_in=0x100 before the result -> no iq pulse for 0x8; line 0x8 is filled; next fetch starts at 0x100.
- Conflict: with INDEX_BITS=6, fill 0x0 then 0x100 -> 0x100 evicts 0x0; re-fetching 0x0 misses.
- Invalidate: cache warm at 0x0, pulse icache_inval_in, fetch 0x0 -> miss and mc request issued.
- rdy low / async reset: drop rdy mid-MISS for 5 cycles -> state and outputs frozen; assert rst_n=0 asynchronously mid-MISS -> all outputs 0 without waiting for a clock edge.
